uart_tx_ctrl: RTL and testbench
===============================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the number of payload bits per frame.
REQ-002 SHALL have parameter MUX_SEL_WIDTH, default 3, meaning the width of the mux select output.
REQ-003 SHALL have port CLK  input  1  meaning the bit clock; one transmitted bit per cycle.
REQ-004 SHALL have port RST  input  1  meaning reset, asynchronous, active-low.
REQ-005 SHALL have port p_data  input  DATA_WIDTH  meaning the parallel payload.
REQ-006 SHALL have port data_valid  input  1  meaning p_data is offered for transmission.
REQ-007 SHALL have port par_en  input  1  meaning a parity bit is inserted in the frame.
REQ-008 SHALL have port par_typ  input  1  meaning the parity type: 0 = even, 1 = odd.
REQ-009 SHALL have port mux_sel  output  MUX_SEL_WIDTH  meaning the registered select to the TX output mux.
REQ-010 SHALL have port ser_data  output  1  meaning the current serialized payload bit.
REQ-011 SHALL have port par  output  1  meaning the computed parity bit.
REQ-012 SHALL have port busy  output  1  meaning a frame is in progress.

Function
REQ-013 SHALL implement FSM states IDLE=000, START=001, DATA=010, PARITY=011 and STOP=100, and SHALL drive mux_sel equal to the current state.
REQ-014 SHALL, in IDLE with data_valid=1, capture p_data, par_en and par_typ at the clock edge and enter START.
REQ-015 SHALL hold START for exactly 1 cycle, then enter DATA.
REQ-016 SHALL hold DATA for exactly DATA_WIDTH cycles: LSB first, ser_data = captured[bit_cnt], bit_cnt counting 0..DATA_WIDTH-1.
REQ-017 SHALL, after the last data bit, go to PARITY if the captured par_en=1, else go to STOP.
REQ-018 SHALL hold PARITY for 1 cycle and SHALL hold STOP for 1 cycle; STOP then goes to IDLE (see REQ-028).
REQ-019 SHALL compute par from the captured data at capture time: even = XOR of all bits; odd = inverted XOR; par is stable for the whole frame.
REQ-020 SHALL drive busy = 1 in every state except IDLE.
REQ-021 SHALL ignore data_valid, p_data, par_en and par_typ while busy=1, except as in REQ-028.
REQ-022 SHALL drive ser_data = 0 when not in DATA.
REQ-023 SHALL make the frame length 1 + DATA_WIDTH + par_en + 1 cycles.
REQ-024 SHALL make bit_cnt wrap to 0 on leaving DATA; no other counter wraps.

Reset
REQ-025 SHALL, on RST=0, immediately force state IDLE, mux_sel=000, busy=0, ser_data=0, par=0, bit_cnt=0 and captured data=0.
REQ-026 SHALL abandon any frame in progress on reset mid-frame, with no resume; the first edge after release with data_valid=1 starts a fresh frame.

Configuration
REQ-027 SHALL support macro UART_TX_BACK2BACK_EN.
REQ-028 SHALL, with UART_TX_BACK2BACK_EN defined and data_valid=1 during STOP, capture new data at that edge and go STOP to START with no IDLE cycle; without the macro, STOP always goes to IDLE and data_valid in STOP is ignored.

Structure
REQ-029 SHALL place the state encodings, MUX_SEL_WIDTH and DATA_WIDTH defaults in shared package uart_tx_pkg, used by both this block and the TX mux.
REQ-030 SHALL instantiate one sub-module, uart_tx_serializer, holding the data register, bit counter and parity logic, with the FSM in uart_tx_ctrl.

Verification
REQ-031 SHALL test 0xA5, par_en=1, par_typ=0 -> mux_sel 1,2x8,3,4,0; ser_data during DATA 1,0,1,0,0,1,0,1; par=0; busy high for 11 cycles.
REQ-032 SHALL test 0xFF, par_en=1, par_typ=1 -> par=1, frame length 11 cycles.
REQ-033 SHALL test 0x3C, par_en=0 -> no PARITY state, mux_sel goes DATA->STOP, busy high for 10 cycles.
REQ-034 SHALL test data_valid pulsed with 0x00 during DATA of a 0xA5 frame -> the 0xA5 frame completes unchanged, then IDLE, and 0x00 is never sent.
REQ-035 SHALL test RST=0 asserted in the 4th DATA cycle -> outputs reset to zero at once, then a new 0x81 frame transmits correctly.
REQ-036 SHALL test, with UART_TX_BACK2BACK_EN, data_valid held high with 0x11 then 0x22 -> the STOP of frame 1 is followed directly by the START of frame 2; without the macro, exactly 1 IDLE cycle separates the frames.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared UART TX definitions: frame FSM encodings (also the TX output mux select) and default widths.
// The encodings must match the TX mux select decode.
package uart_tx_pkg;

  localparam int UART_DATA_WIDTH    = 8;
  localparam int UART_MUX_SEL_WIDTH = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_START  = 3'b001,
    ST_DATA   = 3'b010,
    ST_PARITY = 3'b011,
    ST_STOP   = 3'b100
  } tx_state_e;

  function automatic logic tx_parity(input logic data_xor, input logic odd);
    return data_xor ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Frame datapath: payload register, LSB-first bit counter and parity bit.
// Parity is fixed at load time, so it stays stable for the whole frame.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  par_typ_i,
  input  logic                  shift_i,
  output logic                  ser_o,
  output logic                  par_o,
  output logic                  last_o
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_q;
  logic [CNT_W-1:0]      cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      par_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (load_i) begin
        data_q <= data_i;
        par_q  <= tx_parity(^data_i, par_typ_i);
      end
      // The counter only wraps on the final data bit.
      if (shift_i) begin
        cnt_q <= last_o ? '0 : cnt_q + CNT_W'(1);
      end
    end
  end

  assign last_o = (cnt_q == CNT_W'(DATA_WIDTH - 1));
  assign ser_o  = data_q[cnt_q];
  assign par_o  = par_q;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX frame controller: START, DATA_WIDTH data bits, optional PARITY, STOP; state doubles as mux select.
// Define UART_TX_BACK2BACK_EN to let data_valid in STOP chain the next frame with no IDLE cycle.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH    = UART_DATA_WIDTH,
  parameter int MUX_SEL_WIDTH = UART_MUX_SEL_WIDTH
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    p_data,
  input  logic                     data_valid,
  input  logic                     par_en,
  input  logic                     par_typ,
  output logic [MUX_SEL_WIDTH-1:0] mux_sel,
  output logic                     ser_data,
  output logic                     par,
  output logic                     busy
);

`ifdef UART_TX_BACK2BACK_EN
  localparam bit BACK2BACK = 1'b1;
`else
  localparam bit BACK2BACK = 1'b0;
`endif

  tx_state_e state_q, state_d;
  logic      par_en_q;
  logic      load, shift, ser_bit, last_bit;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      par_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        par_en_q <= par_en;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (data_valid) state_d = ST_START;
      ST_START:  state_d = ST_DATA;
      ST_DATA:   if (last_bit) state_d = par_en_q ? ST_PARITY : ST_STOP;
      ST_PARITY: state_d = ST_STOP;
      ST_STOP:   state_d = (BACK2BACK && data_valid) ? ST_START : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    mux_sel  = MUX_SEL_WIDTH'(state_q);
    shift    = (state_q == ST_DATA);
    ser_data = shift & ser_bit;
    load     = data_valid &&
               ((state_q == ST_IDLE) || (BACK2BACK && (state_q == ST_STOP)));
  end

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .clk       (CLK),
    .rst_n     (RST),
    .load_i    (load),
    .data_i    (p_data),
    .par_typ_i (par_typ),
    .shift_i   (shift),
    .ser_o     (ser_bit),
    .par_o     (par),
    .last_o    (last_bit)
  );

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_uart_tx_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] p_data = 8'h00;
  logic       data_valid = 1'b0;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic [2:0] mux_sel;
  logic       ser_data, par, busy;

  int n_chk = 0;
  int n_pass = 0;

  logic [2:0] ms [32];
  logic       sd [32];
  logic       bz [32];
  logic       pr [32];

  always #5 CLK = ~CLK;

  uart_tx_ctrl dut (
    .CLK        (CLK),
    .RST        (RST),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .mux_sel    (mux_sel),
    .ser_data   (ser_data),
    .par        (par),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Offer one payload for a single cycle; returns at the falling edge where START is visible.
  task automatic start(input logic [7:0] d, input logic pe, input logic pt);
    @(negedge CLK);
    p_data = d; par_en = pe; par_typ = pt; data_valid = 1'b1;
    @(negedge CLK);
    data_valid = 1'b0;
  endtask

  task automatic capture(input int n, input int ev_at, input logic [7:0] ev_data,
                         input logic ev_typ, input int off_at);
    for (int i = 0; i < n; i++) begin
      ms[i] = mux_sel; sd[i] = ser_data; bz[i] = busy; pr[i] = par;
      if (i == ev_at) begin
        data_valid = 1'b1; p_data = ev_data; par_typ = ev_typ;
      end
      if (i == off_at) data_valid = 1'b0;
      @(negedge CLK);
    end
  endtask

  task automatic check_frame(input string tag, input int base, input logic [7:0] d,
                             input logic pe, input logic ep, input int len);
    logic [7:0] b;
    int         e;
    for (int i = 0; i < len; i++) begin
      if (i == 0) e = 1;
      else if (i <= 8) e = 2;
      else if (i == len - 1) e = 4;
      else e = pe ? 3 : 4;
      check($sformatf("%s mux[%0d]", tag, i), 32'(ms[base+i]), 32'(e));
    end
    for (int i = 0; i < 8; i++) b[i] = sd[base+1+i];
    check({tag, " ser_bits"}, 32'(b), 32'(d));
    check({tag, " ser_start"}, 32'(sd[base]), 32'(0));
    check({tag, " ser_stop"}, 32'(sd[base+len-1]), 32'(0));
    check({tag, " par_first"}, 32'(pr[base]), 32'(ep));
    check({tag, " par_last"}, 32'(pr[base+len-1]), 32'(ep));
  endtask

  task automatic check_lone(input string tag, input int n, input int len);
    int cnt = 0;
    for (int i = 0; i < n; i++) cnt += int'(bz[i]);
    check({tag, " busy_cycles"}, 32'(cnt), 32'(len));
    check({tag, " idle_after"}, 32'(ms[len]), 32'(0));
  endtask

  initial begin
    int gap;
    int s2;

    #2 RST = 1'b0;
    #1;
    check("rst mux", 32'(mux_sel), 32'(0));
    check("rst busy", 32'(busy), 32'(0));
    check("rst ser", 32'(ser_data), 32'(0));
    check("rst par", 32'(par), 32'(0));
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("idle busy", 32'(busy), 32'(0));

    // 0xA5 even parity: four ones -> par 0, 11-cycle frame
    start(8'hA5, 1'b1, 1'b0);
    capture(14, -1, 8'h00, 1'b0, -1);
    check_frame("a5", 0, 8'hA5, 1'b1, 1'b0, 11);
    check_lone("a5", 14, 11);

    // 0xFF odd parity: eight ones -> par 1
    start(8'hFF, 1'b1, 1'b1);
    capture(14, -1, 8'h00, 1'b0, -1);
    check_frame("ff", 0, 8'hFF, 1'b1, 1'b1, 11);
    check_lone("ff", 14, 11);

    // 0x3C no parity: DATA goes straight to STOP, 10 cycles
    start(8'h3C, 1'b0, 1'b0);
    capture(14, -1, 8'h00, 1'b0, -1);
    check_frame("3c", 0, 8'h3C, 1'b0, 1'b0, 10);
    check_lone("3c", 14, 10);

    // 0x00 odd offered mid-DATA must be ignored (would flip par to 1)
    start(8'hA5, 1'b1, 1'b0);
    capture(16, 3, 8'h00, 1'b1, 4);
    check_frame("ign", 0, 8'hA5, 1'b1, 1'b0, 11);
    check_lone("ign", 16, 11);
    check("ign stays_idle", 32'(ms[15]), 32'(0));

    // reset in the 4th DATA cycle of 0xFF odd, then 0x81 odd (two ones -> par 1)
    start(8'hFF, 1'b1, 1'b1);
    capture(4, -1, 8'h00, 1'b0, -1);
    check("pre_rst mux", 32'(mux_sel), 32'(2));
    check("pre_rst ser", 32'(ser_data), 32'(1));
    check("pre_rst par", 32'(par), 32'(1));
    RST = 1'b0;
    #1;
    check("mid_rst mux", 32'(mux_sel), 32'(0));
    check("mid_rst busy", 32'(busy), 32'(0));
    check("mid_rst ser", 32'(ser_data), 32'(0));
    check("mid_rst par", 32'(par), 32'(0));
    @(negedge CLK);
    RST = 1'b1;
    start(8'h81, 1'b1, 1'b1);
    capture(14, -1, 8'h00, 1'b0, -1);
    check_frame("81", 0, 8'h81, 1'b1, 1'b1, 11);
    check_lone("81", 14, 11);

    // data_valid held: 0x11 then 0x22, both even parity -> par 0
    @(negedge CLK);
    p_data = 8'h11; par_en = 1'b1; par_typ = 1'b0; data_valid = 1'b1;
    @(negedge CLK);
    capture(26, 0, 8'h22, 1'b0, 12);
`ifdef UART_TX_BACK2BACK_EN
    s2 = 11;
`else
    s2 = 12;
`endif
    check_frame("b2b f1", 0, 8'h11, 1'b1, 1'b0, 11);
    check_frame("b2b f2", s2, 8'h22, 1'b1, 1'b0, 11);
    gap = 0;
    for (int i = 11; i < 15; i++) if (ms[i] == 3'd0) gap++;
`ifdef UART_TX_BACK2BACK_EN
    check("b2b idle_gap", 32'(gap), 32'(0));
`else
    check("b2b idle_gap", 32'(gap), 32'(1));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
